// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD-to-binary converter.
// State encoding and the largest legal BCD digit.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_to_bin_serial_if.sv
// Start/busy/done handshake bundle between the BCD capture side and the converter.
// The master drives the request, the slave returns status and result.
interface bcd_to_bin_serial_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  err,
        input  bin_out
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output err,
        output bin_out
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// One BCD field correction for reverse double-dabble.
// A field that reached 8+ after a right shift borrowed a ten; take back 3.
module bcd_digit_adjust (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd8) ? din - 4'd3 : din;
endmodule

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter: reverse double-dabble, one shift per clock.
// Invalid digits short-circuit straight to DONE with err set and a zero result.
module bcd_to_bin_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    bcd_to_bin_serial_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    logic [SR_W-1:0]    sreg;
    logic [SR_W-1:0]    shifted;
    logic [SR_W-1:0]    adjusted;
    logic [CNT_W-1:0]   count;
    logic               bad;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [BIN_W-1:0]   bin_q;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > BCD_MAX) begin
                bad = 1'b1;
            end
        end
    end

    assign shifted = sreg >> 1;

    // Only the BCD fields are corrected; the binary tail shifts through untouched.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (shifted[BIN_W+4*g +: 4]),
            .dout (adjusted[BIN_W+4*g +: 4])
        );
    end

    assign adjusted[BIN_W-1:0] = shifted[BIN_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            bin_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bad) begin
                            err_q  <= 1'b1;
                            bin_q  <= '0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err_q <= 1'b0;
                            sreg  <= {bus.bcd_in, {BIN_W{1'b0}}};
                            count <= CNT_W'(BIN_W);
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sreg  <= adjusted;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        bin_q  <= adjusted[BIN_W-1:0];
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Directed and table-driven bench for the serial BCD-to-binary converter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_to_bin_serial;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_to_bin_serial_if #(.DIGITS(2), .BIN_W(7)) bus ();

    bcd_to_bin_serial #(.DIGITS(2), .BIN_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bcd;
        int         lat;
        int         bin;
        int         err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One conversion; bcd_in is scrambled after accept to prove it was captured.
    task automatic conv(input logic [7:0] b, input int lat, input int eb,
                        input int ee, input string nm);
        int k;
        int busy_bad;
        busy_bad = 0;
        @(negedge clk);
        bus.bcd_in = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bcd_in = 8'hFF;
        k = 1;
        while (!bus.done && k < 40) begin
            if (!bus.busy) busy_bad++;
            @(negedge clk);
            k++;
        end
        chk({nm, " done_seen"}, int'(bus.done), 1);
        chk({nm, " latency"}, k, lat);
        chk({nm, " bin_out"}, int'(bus.bin_out), eb);
        chk({nm, " err"}, int'(bus.err), ee);
        chk({nm, " busy_during"}, busy_bad + (bus.busy ? 0 : 1), 0);
        @(negedge clk);
        chk({nm, " done_width"}, int'(bus.done), 0);
        chk({nm, " busy_after"}, int'(bus.busy), 0);
    endtask

    initial begin
        int k;
        int k1;
        int hi;
        int lo;
        int e;
        checks = 0;
        errors = 0;

        vecs[0] = '{8'h99, 8, 99, 0};
        vecs[1] = '{8'h00, 8, 0, 0};
        vecs[2] = '{8'h42, 8, 42, 0};
        vecs[3] = '{8'h17, 8, 17, 0};
        vecs[4] = '{8'h5A, 1, 0, 1};
        vecs[5] = '{8'h10, 8, 10, 0};
        vecs[6] = '{8'hA0, 1, 0, 1};
        vecs[7] = '{8'h09, 8, 9, 0};
        vecs[8] = '{8'hFF, 1, 0, 1};
        vecs[9] = '{8'h90, 8, 90, 0};

        bus.start  = 1'b0;
        bus.bcd_in = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset err", int'(bus.err), 0);
        chk("reset bin", int'(bus.bin_out), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            conv(vecs[i].bcd, vecs[i].lat, vecs[i].bin, vecs[i].err,
                 $sformatf("vec%0d", i));
        end

        // Held start: second conversion re-triggers from IDLE with the new value.
        @(negedge clk);
        bus.bcd_in = 8'h63;
        bus.start  = 1'b1;
        k  = 0;
        k1 = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (k == 3) bus.bcd_in = 8'h21;
            if (bus.done && k1 == 0) begin
                k1 = k;
                chk("held first bin", int'(bus.bin_out), 63);
            end else if (bus.done) begin
                break;
            end
        end
        bus.start = 1'b0;
        chk("held first latency", k1, 8);
        chk("held second latency", k, 17);
        chk("held second bin", int'(bus.bin_out), 21);
        @(negedge clk);
        chk("held done_width", int'(bus.done), 0);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a shift.
        bus.bcd_in = 8'h88;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset busy_before", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midreset busy", int'(bus.busy), 0);
        chk("midreset bin", int'(bus.bin_out), 0);
        chk("midreset err", int'(bus.err), 0);
        e = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) e++;
        end
        chk("midreset no_done", e, 0);
        rst = 1'b0;
        conv(8'h88, 8, 88, 0, "after_reset");

        for (int i = 0; i < 100; i++) begin
            conv({4'(i / 10), 4'(i % 10)}, 8, i, 0, $sformatf("sweep%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                hi = $urandom_range(10, 15);
                lo = $urandom_range(0, 15);
            end else begin
                hi = $urandom_range(0, 15);
                lo = $urandom_range(10, 15);
            end
            conv({4'(hi), 4'(lo)}, 1, 0, 1, $sformatf("inval%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
